// File: rtl/imem_fetch_if.sv
// Fetch-unit bus bundle: imem address/data port, redirect request and the
// valid/ready instruction output toward decode.
interface imem_fetch_if #(
  parameter int unsigned n = 32,
  parameter int unsigned r = 6
);
  logic [r-1:0] imem_addr;
  logic [n-1:0] imem_data;
  logic         redirect_valid;
  logic [r-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_instr;
  logic [r-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: PC register driving a combinational imem,
// 2-entry FIFO of {instr, pc} toward decode, single-cycle redirect.
module imem_fetch_unit #(
  parameter int unsigned n = 32,
  parameter int unsigned r = 6
) (
  input logic          clk,
  input logic          reset,
  imem_fetch_if.master bus
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } occ_e;

  occ_e         occ_q, occ_d;
  logic [r-1:0] pc_q, pc_d;
  logic [n-1:0] head_instr_q, head_instr_d;
  logic [r-1:0] head_pc_q, head_pc_d;
  logic [n-1:0] tail_instr_q, tail_instr_d;
  logic [r-1:0] tail_pc_q, tail_pc_d;
  logic         pop;
  logic         fetch;

  always_comb begin
    occ_d        = occ_q;
    pc_d         = pc_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    pop          = (occ_q != EMPTY) && bus.out_ready;
    fetch        = !bus.redirect_valid && ((occ_q != FULL) || pop);

    if (bus.redirect_valid) begin
      occ_d = EMPTY;
      pc_d  = bus.redirect_pc;
    end else begin
      if (fetch) pc_d = pc_q + r'(1);
      // Head is the registered output; the new word lands in the first free
      // slot after any pop has shifted the tail forward.
      unique case (occ_q)
        EMPTY: begin
          if (fetch) begin
            head_instr_d = bus.imem_data;
            head_pc_d    = pc_q;
            occ_d        = ONE;
          end
        end
        ONE: begin
          if (pop && fetch) begin
            head_instr_d = bus.imem_data;
            head_pc_d    = pc_q;
          end else if (fetch) begin
            tail_instr_d = bus.imem_data;
            tail_pc_d    = pc_q;
            occ_d        = FULL;
          end else if (pop) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            if (fetch) begin
              tail_instr_d = bus.imem_data;
              tail_pc_d    = pc_q;
            end else begin
              occ_d = ONE;
            end
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q        <= EMPTY;
      pc_q         <= '0;
      head_instr_q <= '0;
      head_pc_q    <= '0;
      tail_instr_q <= '0;
      tail_pc_q    <= '0;
    end else begin
      occ_q        <= occ_d;
      pc_q         <= pc_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = (occ_q != EMPTY);
  assign bus.out_instr = head_instr_q;
  assign bus.out_pc    = head_pc_q;

endmodule
